// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types and range-check helpers for the BCD time-of-day counter.
//   bcd_t        : one BCD digit (4 bits)
//   bcd_time_t   : HH:MM:SS as six packed BCD digits, hr_hi in the MSBs
//   hour_ok()    : hour pair is valid BCD and does not exceed hour_max
//   pair_ok()    : minute/second pair is valid BCD with hi <= hi_max
//   time_ok()    : full HH:MM:SS range check
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_HI_MAX = 4'd5;
  localparam bcd_t MIN_HI_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX  = 4'd9;

  typedef struct packed {
    bcd_t hr_hi;
    bcd_t hr_lo;
    bcd_t min_hi;
    bcd_t min_lo;
    bcd_t sec_hi;
    bcd_t sec_lo;
  } bcd_time_t;

  function automatic logic hour_ok(bcd_t hi, bcd_t lo, logic [7:0] hour_max);
    logic [7:0] value;
    value = ({4'd0, hi} * 8'd10) + {4'd0, lo};
    return (hi <= DIGIT_MAX) && (lo <= DIGIT_MAX) && (value <= hour_max);
  endfunction

  function automatic logic pair_ok(bcd_t hi, bcd_t lo, bcd_t hi_max);
    return (hi <= hi_max) && (lo <= DIGIT_MAX);
  endfunction

  function automatic logic time_ok(bcd_time_t t, logic [7:0] hour_max);
    return hour_ok(t.hr_hi, t.hr_lo, hour_max) &&
           pair_ok(t.min_hi, t.min_lo, MIN_HI_MAX) &&
           pair_ok(t.sec_hi, t.sec_lo, SEC_HI_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One mod-(max_value+1) BCD digit. Load has priority over increment.
//   clk, rst_n  : clock, async active-low reset (value clears to 0)
//   inc         : advance the digit this cycle
//   max_value   : last value before wrapping to 0
//   load        : take load_value this cycle
//   load_value  : digit to load
//   value       : registered digit
//   next_value  : value the register takes on the coming edge
//   carry_out   : inc and value == max_value (digit wraps this edge)
// -----------------------------------------------------------------------------
module bcd_digit_counter
  import clock_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  bcd_t max_value,
  input  logic load,
  input  bcd_t load_value,
  output bcd_t value,
  output bcd_t next_value,
  output logic carry_out
);

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    next_value = value;
    if (load) begin
      next_value = load_value;
    end else if (inc) begin
      next_value = (value == max_value) ? 4'd0 : value + 4'd1;
    end
  end

  assign carry_out = inc && (value == max_value);

  // NOTE: sequential state uses non-blocking assignment so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= next_value;
  end

endmodule

// File: rtl/bcd_time_counter.sv
// -----------------------------------------------------------------------------
// bcd_time_counter
// Free-running HH:MM:SS counter in six BCD digits, advanced by an internal
// one-second prescaler, with range-checked synchronous load.
//
// Optional feature macro: BCD_TIME_ALARM_EN (adds an HH:MM alarm).
//
// Parameters:
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   HOUR_MAX  last hour before wrap to 00 (1..23, decimal)
// Ports:
//   clk, rst_n          clock, async active-low reset
//   run                 1 = prescaler counts, 0 = frozen
//   load, ld_*          one-cycle load pulse and BCD load digits
//   sec_*/min_*/hr_*    registered time digits
//   tick                pulse on the cycle the time advances
//   day_wrap            pulse when HOUR_MAX:59:59 rolls to 00:00:00
//   load_err            pulse one cycle after a rejected load / al_set
//   al_set, al_*        (alarm build) latch alarm HH:MM
//   alarm               (alarm build) pulse with tick when time hits HH:MM:00
// -----------------------------------------------------------------------------
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [3:0] ld_sec_lo,
  input  logic [3:0] ld_sec_hi,
  input  logic [3:0] ld_min_lo,
  input  logic [3:0] ld_min_hi,
  input  logic [3:0] ld_hr_lo,
  input  logic [3:0] ld_hr_hi,
`ifdef BCD_TIME_ALARM_EN
  input  logic       al_set,
  input  logic [3:0] al_hr_lo,
  input  logic [3:0] al_hr_hi,
  input  logic [3:0] al_min_lo,
  input  logic [3:0] al_min_hi,
  output logic       alarm,
`endif
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic       tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int unsigned    PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
  localparam logic [7:0]     HOUR_MAX_B = 8'(HOUR_MAX);
  localparam bcd_t           HR_HI_LAST = 4'(HOUR_MAX / 10);
  localparam bcd_t           HR_LO_LAST = 4'(HOUR_MAX % 10);

  logic [PW-1:0] presc;
  bcd_time_t     ld_time, next_time;
  logic          load_ok, load_bad, term, adv, hr_wrap, err_any;
  logic          c_sec_lo, c_sec_hi, c_min_lo, c_min_hi, c_hr_lo, c_hr_hi;

  assign ld_time  = {ld_hr_hi, ld_hr_lo, ld_min_hi, ld_min_lo, ld_sec_hi, ld_sec_lo};
  assign load_ok  = load && time_ok(ld_time, HOUR_MAX_B);
  assign load_bad = load && !load_ok;

  // A valid load overrides a coincident terminal count; a rejected one does not.
  assign term = run && (presc == PRESC_LAST);
  assign adv  = term && !load_ok;

  // Hour rollover: the full carry chain reaches the hour pair at HOUR_MAX.
  assign hr_wrap = c_min_hi && (hr_hi == HR_HI_LAST) && (hr_lo == HR_LO_LAST);

  // NOTE: registers here are plain flops, so all of them take the async reset;
  // there is no storage array that would need to stay out of the reset tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load_ok) begin
      presc <= '0;
    end else if (run) begin
      presc <= term ? '0 : presc + PRESC_ONE;
    end
  end

  bcd_digit_counter u_sec_lo (
    .clk(clk), .rst_n(rst_n), .inc(adv), .max_value(DIGIT_MAX),
    .load(load_ok), .load_value(ld_sec_lo),
    .value(sec_lo), .next_value(next_time.sec_lo), .carry_out(c_sec_lo)
  );

  bcd_digit_counter u_sec_hi (
    .clk(clk), .rst_n(rst_n), .inc(c_sec_lo), .max_value(SEC_HI_MAX),
    .load(load_ok), .load_value(ld_sec_hi),
    .value(sec_hi), .next_value(next_time.sec_hi), .carry_out(c_sec_hi)
  );

  bcd_digit_counter u_min_lo (
    .clk(clk), .rst_n(rst_n), .inc(c_sec_hi), .max_value(DIGIT_MAX),
    .load(load_ok), .load_value(ld_min_lo),
    .value(min_lo), .next_value(next_time.min_lo), .carry_out(c_min_lo)
  );

  bcd_digit_counter u_min_hi (
    .clk(clk), .rst_n(rst_n), .inc(c_min_lo), .max_value(MIN_HI_MAX),
    .load(load_ok), .load_value(ld_min_hi),
    .value(min_hi), .next_value(next_time.min_hi), .carry_out(c_min_hi)
  );

  // On hour rollover hr_lo's limit drops to its current value so it wraps to
  // 0, and hr_hi is force-loaded with 0 instead of taking the carry.
  bcd_digit_counter u_hr_lo (
    .clk(clk), .rst_n(rst_n), .inc(c_min_hi),
    .max_value(hr_wrap ? HR_LO_LAST : DIGIT_MAX),
    .load(load_ok), .load_value(ld_hr_lo),
    .value(hr_lo), .next_value(next_time.hr_lo), .carry_out(c_hr_lo)
  );

  bcd_digit_counter u_hr_hi (
    .clk(clk), .rst_n(rst_n), .inc(c_hr_lo && !hr_wrap), .max_value(DIGIT_MAX),
    .load(load_ok || hr_wrap), .load_value(load_ok ? ld_hr_hi : 4'd0),
    .value(hr_hi), .next_value(next_time.hr_hi), .carry_out(c_hr_hi)
  );

  // hr_hi never exceeds 2, so its carry is structurally dead.
  logic unused_hr_carry;
  assign unused_hr_carry = c_hr_hi;

`ifdef BCD_TIME_ALARM_EN
  logic al_ok, al_bad, al_armed, al_hit;
  bcd_t al_hr_hi_q, al_hr_lo_q, al_min_hi_q, al_min_lo_q;

  assign al_ok  = al_set && hour_ok(al_hr_hi, al_hr_lo, HOUR_MAX_B) &&
                  pair_ok(al_min_hi, al_min_lo, MIN_HI_MAX);
  assign al_bad = al_set && !al_ok;

  // Compare against the post-update time so alarm lines up with tick.
  assign al_hit = al_armed &&
                  (next_time == {al_hr_hi_q, al_hr_lo_q, al_min_hi_q, al_min_lo_q, 8'h00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_armed    <= 1'b0;
      al_hr_hi_q  <= '0;
      al_hr_lo_q  <= '0;
      al_min_hi_q <= '0;
      al_min_lo_q <= '0;
      alarm       <= 1'b0;
    end else begin
      if (al_ok) begin
        al_armed    <= 1'b1;
        al_hr_hi_q  <= al_hr_hi;
        al_hr_lo_q  <= al_hr_lo;
        al_min_hi_q <= al_min_hi;
        al_min_lo_q <= al_min_lo;
      end
      alarm <= adv && al_hit;
    end
  end

  assign err_any = load_bad || al_bad;
`else
  logic unused_next;
  assign unused_next = ^next_time;
  assign err_any     = load_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= adv;
      day_wrap <= hr_wrap;
      load_err <= err_any;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_time_counter
// Directed bench for bcd_time_counter with TICK_DIV=4, HOUR_MAX=23.
// Times are written as 24-bit BCD literals HHMMSS (e.g. 24'h235958).
// Alarm scenario is included when BCD_TIME_ALARM_EN is defined.
// -----------------------------------------------------------------------------
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst_n, run, load;
  logic [3:0] ld_sec_lo, ld_sec_hi, ld_min_lo, ld_min_hi, ld_hr_lo, ld_hr_hi;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic       tick, day_wrap, load_err;
`ifdef BCD_TIME_ALARM_EN
  logic       al_set, alarm;
  logic [3:0] al_hr_lo, al_hr_hi, al_min_lo, al_min_hi;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.TICK_DIV(4), .HOUR_MAX(23)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .ld_sec_lo(ld_sec_lo), .ld_sec_hi(ld_sec_hi),
    .ld_min_lo(ld_min_lo), .ld_min_hi(ld_min_hi),
    .ld_hr_lo(ld_hr_lo), .ld_hr_hi(ld_hr_hi),
`ifdef BCD_TIME_ALARM_EN
    .al_set(al_set), .al_hr_lo(al_hr_lo), .al_hr_hi(al_hr_hi),
    .al_min_lo(al_min_lo), .al_min_hi(al_min_hi), .alarm(alarm),
`endif
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .hr_lo(hr_lo), .hr_hi(hr_hi),
    .tick(tick), .day_wrap(day_wrap), .load_err(load_err)
  );

  function automatic logic [23:0] now();
    return {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
  endfunction

  task automatic set_load(input logic [23:0] v);
    {ld_hr_hi, ld_hr_lo, ld_min_hi, ld_min_lo, ld_sec_hi, ld_sec_lo} = v;
  endtask

  // Counts falling edges until tick is seen; 20 means it never came.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (tick) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; load = 1'b0; set_load(24'h0);
`ifdef BCD_TIME_ALARM_EN
    al_set = 1'b0; {al_hr_hi, al_hr_lo, al_min_hi, al_min_lo} = 16'h0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (now() !== 24'h000000) begin
      errors++; $display("FAIL reset_time: got %h want 000000", now());
    end
    vectors++;
    if ({tick, day_wrap, load_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {tick, day_wrap, load_err});
    end
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  task automatic test_count();
    int n;
    for (int t = 0; t < 60; t++) begin
      wait_tick(n);
      vectors++;
      if (n !== 4) begin
        errors++; $display("FAIL tick_interval[%0d]: got %0d want 4", t, n);
      end
      if (t == 9) begin
        vectors++;
        if (now() !== 24'h000010) begin
          errors++; $display("FAIL count_10s: got %h want 000010", now());
        end
      end
    end
    vectors++;
    if (now() !== 24'h000100) begin
      errors++; $display("FAIL count_60s: got %h want 000100", now());
    end
    @(negedge clk);
    vectors++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL tick_width: got %b want 0", tick);
    end
  endtask

  task automatic test_day_wrap();
    int n;
    set_load(24'h235958); load = 1'b1;
    @(negedge clk); load = 1'b0;
    vectors++;
    if (now() !== 24'h235958 || tick !== 1'b0) begin
      errors++; $display("FAIL load_valid: got %h tick %b want 235958 tick 0", now(), tick);
    end
    wait_tick(n);
    vectors++;
    if (n !== 4 || now() !== 24'h235959 || day_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_pre: got n=%0d %h dw=%b want n=4 235959 dw=0", n, now(), day_wrap);
    end
    wait_tick(n);
    vectors++;
    if (n !== 4 || now() !== 24'h000000 || day_wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_tick: got n=%0d %h dw=%b want n=4 000000 dw=1", n, now(), day_wrap);
    end
    @(negedge clk);
    vectors++;
    if (day_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_width: got %b want 0", day_wrap);
    end
  endtask

  task automatic test_load_err();
    logic [23:0] bad [3];
    logic [23:0] e;
    int n;
    bad[0] = 24'h000060;  // sec_hi = 6
    bad[1] = 24'h240000;  // hour 24
    bad[2] = 24'h000A00;  // non-BCD digit
    for (int i = 0; i < 3; i++) begin
      e = 24'(2 * i + 1);
      wait_tick(n);  // align just after a tick: prescaler is 0
      vectors++;
      if (now() !== e) begin
        errors++; $display("FAIL err_pre[%0d]: got %h want %h", i, now(), e);
      end
      set_load(bad[i]); load = 1'b1;
      @(negedge clk); load = 1'b0;
      vectors++;
      if (load_err !== 1'b1 || now() !== e || tick !== 1'b0) begin
        errors++; $display("FAIL err_pulse[%0d]: got err=%b %h tick=%b want err=1 %h tick=0",
                           i, load_err, now(), tick, e);
      end
      @(negedge clk);
      vectors++;
      if (load_err !== 1'b0) begin
        errors++; $display("FAIL err_width[%0d]: got %b want 0", i, load_err);
      end
      // Prescaler untouched: it is now 2, so the tick arrives in 2 cycles.
      wait_tick(n);
      vectors++;
      if (n !== 2 || now() !== e + 24'd1) begin
        errors++; $display("FAIL err_presc[%0d]: got n=%0d %h want n=2 %h", i, n, now(), e + 24'd1);
      end
    end
  endtask

  task automatic test_load_on_terminal();
    int n;
    repeat (3) @(negedge clk);  // prescaler now at terminal count
    set_load(24'h123456); load = 1'b1;
    @(negedge clk); load = 1'b0;
    vectors++;
    if (now() !== 24'h123456 || tick !== 1'b0) begin
      errors++; $display("FAIL term_load: got %h tick=%b want 123456 tick=0", now(), tick);
    end
    wait_tick(n);
    vectors++;
    if (n !== 4 || now() !== 24'h123457) begin
      errors++; $display("FAIL term_next: got n=%0d %h want n=4 123457", n, now());
    end
    repeat (3) @(negedge clk);
    set_load(24'h240000); load = 1'b1;
    @(negedge clk); load = 1'b0;
    vectors++;
    if (tick !== 1'b1 || load_err !== 1'b1 || now() !== 24'h123458) begin
      errors++; $display("FAIL term_badload: got tick=%b err=%b %h want tick=1 err=1 123458",
                         tick, load_err, now());
    end
  endtask

  task automatic test_run_freeze();
    int n;
    @(negedge clk);  // prescaler = 1
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (tick !== 1'b0 || now() !== 24'h123458) begin
        errors++; $display("FAIL frozen[%0d]: got tick=%b %h want tick=0 123458", i, tick, now());
      end
    end
    run = 1'b1;
    wait_tick(n);
    vectors++;
    if (n !== 3 || now() !== 24'h123459) begin
      errors++; $display("FAIL resume: got n=%0d %h want n=3 123459", n, now());
    end
    wait_tick(n);
    vectors++;
    if (n !== 4 || now() !== 24'h123500) begin
      errors++; $display("FAIL resume_carry: got n=%0d %h want n=4 123500", n, now());
    end
  endtask

  task automatic test_hour_carry();
    logic [23:0] start [2];
    logic [23:0] want  [2];
    int n;
    start[0] = 24'h095959; want[0] = 24'h100000;
    start[1] = 24'h195959; want[1] = 24'h200000;
    for (int i = 0; i < 2; i++) begin
      set_load(start[i]); load = 1'b1;
      @(negedge clk); load = 1'b0;
      wait_tick(n);
      vectors++;
      if (n !== 4 || now() !== want[i] || day_wrap !== 1'b0) begin
        errors++; $display("FAIL hour_carry[%0d]: got n=%0d %h dw=%b want n=4 %h dw=0",
                           i, n, now(), day_wrap, want[i]);
      end
    end
  endtask

`ifdef BCD_TIME_ALARM_EN
  task automatic test_alarm();
    int n;
    {al_hr_hi, al_hr_lo, al_min_hi, al_min_lo} = 16'h2400; al_set = 1'b1;
    @(negedge clk); al_set = 1'b0;
    vectors++;
    if (load_err !== 1'b1) begin
      errors++; $display("FAIL alarm_bad_set: got err=%b want 1", load_err);
    end
    {al_hr_hi, al_hr_lo, al_min_hi, al_min_lo} = 16'h0001; al_set = 1'b1;
    set_load(24'h000058); load = 1'b1;
    @(negedge clk); al_set = 1'b0; load = 1'b0;
    vectors++;
    if (load_err !== 1'b0 || now() !== 24'h000058) begin
      errors++; $display("FAIL alarm_set: got err=%b %h want err=0 000058", load_err, now());
    end
    wait_tick(n);
    vectors++;
    if (now() !== 24'h000059 || alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_early: got %h al=%b want 000059 al=0", now(), alarm);
    end
    wait_tick(n);
    vectors++;
    if (now() !== 24'h000100 || alarm !== 1'b1) begin
      errors++; $display("FAIL alarm_hit: got %h al=%b want 000100 al=1", now(), alarm);
    end
    @(negedge clk);
    vectors++;
    if (alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_width: got %b want 0", alarm);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (now() !== 24'h000000 || {tick, day_wrap, load_err} !== 3'b000) begin
      errors++; $display("FAIL reset_mid: got %h flags=%b want 000000 flags=000",
                         now(), {tick, day_wrap, load_err});
    end
`ifdef BCD_TIME_ALARM_EN
    vectors++;
    if (alarm !== 1'b0) begin
      errors++; $display("FAIL reset_mid_alarm: got %b want 0", alarm);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(n);
    vectors++;
    if (n !== 4 || now() !== 24'h000001) begin
      errors++; $display("FAIL reset_restart: got n=%0d %h want n=4 000001", n, now());
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_load_err();
    test_load_on_terminal();
    test_run_freeze();
    test_hour_carry();
`ifdef BCD_TIME_ALARM_EN
    test_alarm();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
